// File: rtl/dsp_pkg.sv
// Shared DSP-slice definitions: datapath width, ALUMODE encodings and the
// masked pattern compare used by the pattern detector.
package dsp_pkg;

  localparam int DSP_W = 48;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_ZSUB = 2'b01;
  localparam logic [1:0] ALU_SUBZ = 2'b10;
  localparam logic [1:0] ALU_NADD = 2'b11;

  // A set mask bit excludes that bit position from the comparison.
  function automatic logic masked_eq(input logic [DSP_W-1:0] value,
                                     input logic [DSP_W-1:0] pattern,
                                     input logic [DSP_W-1:0] mask);
    return (((value ^ pattern) & ~mask) == {DSP_W{1'b0}});
  endfunction

endpackage

// File: rtl/pattern_detect.sv
// Masked pattern / inverted-pattern compare of the post-adder result, with the
// one-cycle detect history that produces OVERFLOW and UNDERFLOW.
module pattern_detect
  import dsp_pkg::*;
#(
  parameter int               PREG    = 1,
  parameter logic [DSP_W-1:0] MASK    = 48'h0,
  parameter logic [DSP_W-1:0] PATTERN = 48'h0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             ce_i,
  input  logic [DSP_W-1:0] r_i,
  output logic             pd_o,
  output logic             pbd_o,
  output logic             ovf_o,
  output logic             unf_o
);

  logic pd_d;
  logic pbd_d;

  assign pd_d  = masked_eq(r_i, PATTERN, MASK);
  assign pbd_d = masked_eq(r_i, ~PATTERN, MASK);

  if (PREG != 0) begin : g_reg
    logic pd_q;
    logic pbd_q;
    logic ovf_q;
    logic unf_q;

    // pd_q/pbd_q double as the history: at each enabled edge they still hold
    // the previous result's flags while pd_d/pbd_d describe the new one.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        pd_q  <= 1'b0;
        pbd_q <= 1'b0;
        ovf_q <= 1'b0;
        unf_q <= 1'b0;
      end else if (ce_i) begin
        pd_q  <= pd_d;
        pbd_q <= pbd_d;
        ovf_q <= pd_q & ~pd_d & ~pbd_d;
        unf_q <= pbd_q & ~pd_d & ~pbd_d;
      end
    end

    assign pd_o  = pd_q;
    assign pbd_o = pbd_q;
    assign ovf_o = ovf_q;
    assign unf_o = unf_q;
  end else begin : g_comb
    assign pd_o  = pd_d;
    assign pbd_o = pbd_d;
    assign ovf_o = 1'b0;
    assign unf_o = 1'b0;
  end

endmodule

// File: rtl/post_adder_p_reg.sv
// DSP post-adder/subtractor with optional ALUMODE/CARRYIN input registers and
// the P output register. Pattern detect is built only with PATTERN_DETECT_EN.
module post_adder_p_reg
  import dsp_pkg::*;
#(
  parameter int               PREG       = 1,
  parameter int               ALUMODEREG = 1,
  parameter int               CARRYINREG = 1,
  parameter logic [DSP_W-1:0] MASK       = 48'h0,
  parameter logic [DSP_W-1:0] PATTERN    = 48'h0
) (
  input  logic             CLK,
  input  logic             RSTP,
  input  logic             CEP,
  input  logic             CEALUMODE,
  input  logic             CECARRYIN,
  input  logic [DSP_W-1:0] X_MUX_OUT,
  input  logic [DSP_W-1:0] Y_MUX_OUT,
  input  logic [DSP_W-1:0] Z_MUX_OUT,
  input  logic [1:0]       ALUMODE,
  input  logic             CARRYIN,
  output logic [DSP_W-1:0] P,
  output logic [DSP_W-1:0] PCOUT,
  output logic             CARRYOUT,
  output logic             PATTERNDETECT,
  output logic             PATTERNBDETECT,
  output logic             OVERFLOW,
  output logic             UNDERFLOW
);

  logic [1:0]       alumode_q;
  logic             carryin_q;
  logic [1:0]       alumode_eff;
  logic             cin_eff;
  logic [DSP_W-1:0] sum_xy;
  logic [DSP_W:0]   sum_all;
  logic [DSP_W-1:0] r_d;
  logic             co_d;

  always_ff @(posedge CLK) begin
    if (RSTP) begin
      alumode_q <= 2'b00;
      carryin_q <= 1'b0;
    end else begin
      if (CEALUMODE) alumode_q <= ALUMODE;
      if (CECARRYIN) carryin_q <= CARRYIN;
    end
  end

  assign alumode_eff = (ALUMODEREG != 0) ? alumode_q : ALUMODE;
  assign cin_eff     = (CARRYINREG != 0) ? carryin_q : CARRYIN;

  // Bit 48 of a 49-bit sum equals bit 48 of the full 50-bit sum (modular).
  assign sum_xy  = X_MUX_OUT + Y_MUX_OUT + {{(DSP_W-1){1'b0}}, cin_eff};
  assign sum_all = {1'b0, Z_MUX_OUT} + {1'b0, X_MUX_OUT} + {1'b0, Y_MUX_OUT}
                 + {{DSP_W{1'b0}}, cin_eff};

  always_comb begin
    r_d  = sum_all[DSP_W-1:0];
    co_d = 1'b0;
    case (alumode_eff)
      ALU_ADD: begin
        r_d  = sum_all[DSP_W-1:0];
        co_d = sum_all[DSP_W];
      end
      ALU_ZSUB: r_d = Z_MUX_OUT - sum_xy;
      ALU_SUBZ: r_d = sum_xy - Z_MUX_OUT;
      ALU_NADD: r_d = ~sum_all[DSP_W-1:0];
      default: begin
        r_d  = sum_all[DSP_W-1:0];
        co_d = 1'b0;
      end
    endcase
  end

  if (PREG != 0) begin : g_preg
    logic [DSP_W-1:0] p_q;
    logic             co_q;

    always_ff @(posedge CLK) begin
      if (RSTP) begin
        p_q  <= {DSP_W{1'b0}};
        co_q <= 1'b0;
      end else if (CEP) begin
        p_q  <= r_d;
        co_q <= co_d;
      end
    end

    assign P        = p_q;
    assign CARRYOUT = co_q;
  end else begin : g_pcomb
    assign P        = r_d;
    assign CARRYOUT = co_d;
  end

  assign PCOUT = P;

`ifdef PATTERN_DETECT_EN
  pattern_detect #(
    .PREG    (PREG),
    .MASK    (MASK),
    .PATTERN (PATTERN)
  ) u_pattern_detect (
    .clk_i (CLK),
    .rst_i (RSTP),
    .ce_i  (CEP),
    .r_i   (r_d),
    .pd_o  (PATTERNDETECT),
    .pbd_o (PATTERNBDETECT),
    .ovf_o (OVERFLOW),
    .unf_o (UNDERFLOW)
  );
`else
  assign PATTERNDETECT  = 1'b0;
  assign PATTERNBDETECT = 1'b0;
  assign OVERFLOW       = 1'b0;
  assign UNDERFLOW      = 1'b0;
`endif

endmodule
